// File: rtl/ram_io_responder_if.sv
// Byte-serial memory bus plus UART byte streams between controller/UART (master)
// and the RAM/IO responder (slave).
interface ram_io_responder_if;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  modport master (
    output mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    input  mem_din, io_buffer_full, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  mem_a, mem_wr, mem_dout, tx_ready, rx_data, rx_valid,
    output mem_din, io_buffer_full, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/ram_io_responder.sv
// Memory-bus responder: byte RAM with 1-cycle registered read, UART TX FIFO with
// near-full flow control. Define IO_RX_EN to build the RX FIFO behind the UART data register.
module ram_io_responder #(
  parameter int ADDR_W       = 17,
  parameter int TX_DEPTH_LOG = 4,
  parameter int RX_DEPTH_LOG = 4,
  parameter int FULL_MARGIN  = 2
) (
  input  logic              clk,
  input  logic              rst,
  ram_io_responder_if.slave bus
);
  localparam int TX_DEPTH = 2**TX_DEPTH_LOG;
  localparam logic [TX_DEPTH_LOG:0] C_TX_DEPTH  = (TX_DEPTH_LOG+1)'(TX_DEPTH);
  localparam logic [TX_DEPTH_LOG:0] C_TX_THRESH = (TX_DEPTH_LOG+1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [TX_DEPTH_LOG:0] C_TX_ONE    = (TX_DEPTH_LOG+1)'(1);

  logic [7:0]              r_ram [2**ADDR_W];
  logic [7:0]              r_tx_mem [TX_DEPTH];
  logic [TX_DEPTH_LOG-1:0] r_tx_wr, r_tx_rd;
  logic [TX_DEPTH_LOG:0]   r_tx_cnt, w_tx_cnt_nxt;
  logic [7:0]              r_mem_din;
  logic                    r_full, r_prev_io_rd;
  logic [ADDR_W-1:0]       w_idx;
  logic                    w_io, w_data_sel, w_stat_sel, w_rd_fresh;
  logic                    w_tx_push, w_tx_pop, w_tx_nempty;
  logic                    w_rx_nempty;
  logic [7:0]              w_rx_head;
  logic                    w_unused_a;

  assign w_idx      = bus.mem_a[ADDR_W-1:0];
  assign w_io       = (bus.mem_a[17:16] == 2'b11);
  assign w_data_sel = (bus.mem_a[17:0] == 18'h30000);
  assign w_stat_sel = (bus.mem_a[17:0] == 18'h30004);
  assign w_unused_a = ^bus.mem_a[31:18];
  // Only the first cycle of a held data-register read may pop the RX FIFO.
  assign w_rd_fresh = !bus.mem_wr && w_data_sel && !r_prev_io_rd;

  assign w_tx_nempty = (r_tx_cnt != '0);
  assign w_tx_pop    = w_tx_nempty && bus.tx_ready;
  assign w_tx_push   = bus.mem_wr && w_data_sel && ((r_tx_cnt < C_TX_DEPTH) || w_tx_pop);

  always_comb begin
    w_tx_cnt_nxt = r_tx_cnt;
    if (w_tx_push && !w_tx_pop)      w_tx_cnt_nxt = r_tx_cnt + C_TX_ONE;
    else if (!w_tx_push && w_tx_pop) w_tx_cnt_nxt = r_tx_cnt - C_TX_ONE;
  end

  assign bus.tx_valid       = w_tx_nempty;
  assign bus.tx_data        = w_tx_nempty ? r_tx_mem[r_tx_rd] : 8'h00;
  assign bus.io_buffer_full = r_full;
  assign bus.mem_din        = r_mem_din;

  always_ff @(posedge clk) begin
    if (bus.mem_wr && !w_io) r_ram[w_idx] <= bus.mem_dout;
    if (w_tx_push)           r_tx_mem[r_tx_wr] <= bus.mem_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wr      <= '0;
      r_tx_rd      <= '0;
      r_tx_cnt     <= '0;
      r_full       <= 1'b0;
      r_prev_io_rd <= 1'b0;
      r_mem_din    <= 8'h00;
    end else begin
      r_tx_cnt     <= w_tx_cnt_nxt;
      r_full       <= (w_tx_cnt_nxt >= C_TX_THRESH);
      r_prev_io_rd <= !bus.mem_wr && w_data_sel;
      if (w_tx_push) r_tx_wr <= r_tx_wr + TX_DEPTH_LOG'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_DEPTH_LOG'(1);
      if (!bus.mem_wr) begin
        if (!w_io)           r_mem_din <= r_ram[w_idx];
        else if (w_data_sel) begin
          if (w_rd_fresh)    r_mem_din <= w_rx_head;
        end
        else if (w_stat_sel) r_mem_din <= {6'b0, (r_tx_cnt == C_TX_DEPTH), w_rx_nempty};
        else                 r_mem_din <= 8'h00;
      end
    end
  end

`ifdef IO_RX_EN
  localparam int RX_DEPTH = 2**RX_DEPTH_LOG;
  localparam logic [RX_DEPTH_LOG:0] C_RX_DEPTH = (RX_DEPTH_LOG+1)'(RX_DEPTH);
  localparam logic [RX_DEPTH_LOG:0] C_RX_ONE   = (RX_DEPTH_LOG+1)'(1);

  logic [7:0]              r_rx_mem [RX_DEPTH];
  logic [RX_DEPTH_LOG-1:0] r_rx_wr, r_rx_rd;
  logic [RX_DEPTH_LOG:0]   r_rx_cnt, w_rx_cnt_nxt;
  logic                    r_rx_rdy, w_rx_push, w_rx_pop;

  assign w_rx_nempty  = (r_rx_cnt != '0);
  assign w_rx_head    = w_rx_nempty ? r_rx_mem[r_rx_rd] : 8'h00;
  assign w_rx_push    = bus.rx_valid && r_rx_rdy;
  assign w_rx_pop     = w_rd_fresh && w_rx_nempty;
  assign bus.rx_ready = r_rx_rdy;

  always_comb begin
    w_rx_cnt_nxt = r_rx_cnt;
    if (w_rx_push && !w_rx_pop)      w_rx_cnt_nxt = r_rx_cnt + C_RX_ONE;
    else if (!w_rx_push && w_rx_pop) w_rx_cnt_nxt = r_rx_cnt - C_RX_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wr] <= bus.rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wr  <= '0;
      r_rx_rd  <= '0;
      r_rx_cnt <= '0;
      r_rx_rdy <= 1'b0;
    end else begin
      r_rx_cnt <= w_rx_cnt_nxt;
      r_rx_rdy <= (w_rx_cnt_nxt < C_RX_DEPTH);
      if (w_rx_push) r_rx_wr <= r_rx_wr + RX_DEPTH_LOG'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_DEPTH_LOG'(1);
    end
  end
`else
  logic w_unused_rx;
  assign w_rx_nempty  = 1'b0;
  assign w_rx_head    = 8'h00;
  assign bus.rx_ready = 1'b0;
  assign w_unused_rx  = ^{bus.rx_data, bus.rx_valid};
`endif
endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: queue-based reference model, per-cycle
// expectation queue and TX byte queue checked by an independent monitor.
module tb_ram_io_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_io_responder_if bus();
  ram_io_responder dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0] din;
    logic       full;
    logic       tv;
  } exp_t;

  exp_t       q_exp[$];
  logic [7:0] tx_exp[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] ram_m [logic [31:0]];
  logic       prev_m, rxrdy_m;
  logic [7:0] din_m;
  int         n_vec = 0, n_err = 0, n_txpop = 0;
  bit         mon_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    txq.delete(); tx_exp.delete(); rxq.delete(); q_exp.delete();
    prev_m = 1'b0; rxrdy_m = 1'b0; din_m = 8'h00;
  endtask

  // One bus cycle: drive at negedge, advance the model, queue the expected post-edge state.
  task automatic cyc(logic [31:0] a, logic wr, logic [7:0] d, logic txr, logic rxv, logic [7:0] rxd);
    logic io, dsel, ssel, pop, rx_ne;
    int txn;
    logic [31:0] idx;
    exp_t e;
    bus.mem_a = a; bus.mem_wr = wr; bus.mem_dout = d;
    bus.tx_ready = txr; bus.rx_valid = rxv; bus.rx_data = rxd;
    io = (a[17:16] == 2'b11);
    dsel = (a[17:0] == 18'h30000);
    ssel = (a[17:0] == 18'h30004);
    idx = a & 32'h1FFFF;
    txn = txq.size();
    rx_ne = (rxq.size() > 0);
    pop = (txn > 0) && txr;
    if (!wr) begin
      if (!io) din_m = ram_m[idx];
      else if (dsel) begin
        if (!prev_m) din_m = rx_ne ? rxq.pop_front() : 8'h00;
      end
      else if (ssel) din_m = {6'b0, txn == 16, rx_ne};
      else din_m = 8'h00;
    end else if (!io) ram_m[idx] = d;
`ifdef IO_RX_EN
    if (rxv && rxrdy_m) rxq.push_back(rxd);
    rxrdy_m = (rxq.size() < 16);
`endif
    if (pop) void'(txq.pop_front());
    if (wr && dsel && (txn < 16 || pop)) begin
      txq.push_back(d);
      tx_exp.push_back(d);
    end
    prev_m = !wr && dsel;
    e.din = din_m; e.full = (txq.size() >= 14); e.tv = (txq.size() > 0);
    q_exp.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: sample handshake mid-low-phase, compare registered outputs just after the edge.
  logic       s_en, s_hs;
  logic [7:0] s_td;
  exp_t       e_m;
  initial begin
    forever begin
      @(negedge clk); #2;
      s_en = mon_en; s_hs = bus.tx_valid && bus.tx_ready; s_td = bus.tx_data;
      @(posedge clk); #1;
      if (s_en) begin
        if (s_hs) begin
          n_txpop++;
          if (tx_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL tx_pop: got byte %0h, want no pop (queue empty)", s_td);
          end else chk("tx_data", {24'h0, s_td}, {24'h0, tx_exp.pop_front()});
        end
        if (q_exp.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL exp_queue: got a cycle, want none pending");
        end else begin
          e_m = q_exp.pop_front();
          chk("mem_din", {24'h0, bus.mem_din}, {24'h0, e_m.din});
          chk("io_buffer_full", {31'h0, bus.io_buffer_full}, {31'h0, e_m.full});
          chk("tx_valid", {31'h0, bus.tx_valid}, {31'h0, e_m.tv});
        end
      end
    end
  end

  logic [31:0] addrs [12];
  int base;
  initial begin
    addrs = '{32'h10, 32'h100, 32'h101, 32'h102, 32'h103, 32'h1FFFF, 32'h0ABCD,
              32'hFFF00010, 32'h2ABCD, 32'h30000, 32'h30004, 32'h5_0030000};
    bus.mem_a = 32'h0; bus.mem_wr = 1'b0; bus.mem_dout = 8'h0;
    bus.tx_ready = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_mem_din", {24'h0, bus.mem_din}, 32'h0);
    chk("rst_full", {31'h0, bus.io_buffer_full}, 32'h0);
    chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk("rst_rx_ready", {31'h0, bus.rx_ready}, 32'h0);
    rst = 1'b0;
    mon_en = 1;

    // RAM write/read latency, back-to-back reads
    cyc(32'h10, 1, 8'hA5, 0, 0, 0);
    cyc(32'h10, 0, 0, 0, 0, 0);
    cyc(32'h100, 1, 8'h11, 0, 0, 0);
    cyc(32'h101, 1, 8'h22, 0, 0, 0);
    cyc(32'h102, 1, 8'h33, 0, 0, 0);
    cyc(32'h103, 1, 8'h44, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(32'h100 + i, 0, 0, 0, 0, 0);

    // TX fill past depth, then drain
    for (int i = 0; i < 18; i++) cyc(32'h30000, 1, 8'(8'h80 + i), 0, 0, 0);
    base = n_txpop;
    for (int i = 0; i < 20; i++) cyc(32'h10, 0, 0, 1, 0, 0);
    chk("drain_count", n_txpop - base, 16);
    chk("tx_left", tx_exp.size(), 0);

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 16; i++) cyc(32'h30000, 1, 8'(8'h20 + i), 0, 0, 0);
    cyc(32'h30004, 0, 0, 0, 0, 0);
    cyc(32'h30000, 1, 8'hEE, 1, 0, 0);
    cyc(32'h30004, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) cyc(32'h101, 0, 0, 1, 0, 0);
    chk("tx_left2", tx_exp.size(), 0);

`ifdef IO_RX_EN
    cyc(32'h10, 0, 0, 0, 1, 8'h41);
    cyc(32'h10, 0, 0, 0, 1, 8'h42);
    cyc(32'h30004, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(32'h30000, 0, 0, 0, 0, 0);
    cyc(32'h10, 0, 0, 0, 0, 0);
    cyc(32'h30000, 0, 0, 0, 0, 0);
    cyc(32'h10, 0, 0, 0, 0, 0);
    cyc(32'h30000, 0, 0, 0, 0, 0);
    cyc(32'h30004, 0, 0, 0, 0, 0);
`endif

    // reset with TX holding 5 bytes
    for (int i = 0; i < 5; i++) cyc(32'h30000, 1, 8'(8'h60 + i), 0, 0, 0);
    cyc(32'h103, 1, 8'h5A, 0, 0, 0);
    cyc(32'h103, 0, 0, 0, 0, 0);
    mon_en = 0;
    rst = 1'b1;
    #1;
    chk("rst2_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst2_full", {31'h0, bus.io_buffer_full}, 32'h0);
    chk("rst2_mem_din", {24'h0, bus.mem_din}, 32'h0);
    chk("rst2_tx_data", {24'h0, bus.tx_data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mon_en = 1;
    cyc(32'h103, 0, 0, 0, 0, 0);
    cyc(32'h10, 0, 0, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 9; i++) cyc(addrs[i], 1, 8'($urandom), 0, 0, 0);
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 100; i++) begin
        logic [31:0] a;
        logic wr, txr, rxv;
        a   = addrs[$urandom_range(0, 11)];
        wr  = 1'($urandom_range(0, 1));
        txr = ($urandom_range(0, 5) < blk);
        rxv = 1'($urandom_range(0, 1));
        cyc(a, wr, 8'($urandom), txr, rxv, 8'($urandom));
      end
    end
    for (int i = 0; i < 40; i++) cyc(32'h10, 0, 0, 1, 0, 0);
    chk("final_tx_left", tx_exp.size(), 0);
    mon_en = 0;
    @(negedge clk);
    chk("final_exp_left", q_exp.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
